// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants for the register slice and its skid buffers.
package axil_pkg;

    localparam int AXIL_PROT_W = 3;
    localparam int AXIL_RESP_W = 2;

    localparam logic [AXIL_RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [AXIL_RESP_W-1:0] EXOKAY = 2'b01;
    localparam logic [AXIL_RESP_W-1:0] SLVERR = 2'b10;
    localparam logic [AXIL_RESP_W-1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_skid_buf.sv
// One-deep skid buffer: a main output register backed by a single skid entry.
// The upstream ready is a flop equal to "skid not occupied", so it never has a
// combinational path from the downstream ready.
module axil_skid_buf #(
    parameter int G_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [G_W-1:0] s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [G_W-1:0] m_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           ready_q;
    logic [G_W-1:0] main_p0;
    logic [G_W-1:0] skid_p0;
    logic           in_hs;
    logic           out_hs;

    assign in_hs  = s_valid & ready_q;
    assign out_hs = (state != ST_EMPTY) & m_ready;

    // Next-state selection from the two handshakes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (in_hs) state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (in_hs && !out_hs)      state_nxt = ST_FULL;
                else if (!in_hs && out_hs) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (out_hs) state_nxt = ST_BUSY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Control state and the registered upstream ready (low only while skid holds data).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != ST_FULL);
        end
    end

    // Stage p0: main/skid payload registers; cleared on reset so outputs read zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_p0 <= '0;
            skid_p0 <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (in_hs) main_p0 <= s_data;
                ST_BUSY: begin
                    if (in_hs && out_hs) main_p0 <= s_data;
                    else if (in_hs)      skid_p0 <= s_data;
                end
                ST_FULL:  if (out_hs) main_p0 <= skid_p0;
                default:  ;
            endcase
        end
    end

    assign s_ready = ready_q;
    assign m_valid = (state != ST_EMPTY);
    assign m_data  = main_p0;

endmodule

// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: AW, W and AR each pass through an axil_skid_buf
// (1-cycle latency, full throughput, registered upstream ready).
// Build option: define AXIL_REG_SLICE_RESP_EN to also register the B and R
// channels in the reverse direction; otherwise B and R are plain wires that
// are only forced to zero while i_rst is high.
module axil_reg_slice
    import axil_pkg::*;
#(
    parameter int G_ADDR_W = 20,
    parameter int G_DATA_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // upstream slave port
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [G_ADDR_W-1:0]     s_axil_awaddr,
    input  logic [AXIL_PROT_W-1:0]  s_axil_awprot,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    input  logic [G_DATA_W-1:0]     s_axil_wdata,
    input  logic [G_DATA_W/8-1:0]   s_axil_wstrb,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [AXIL_RESP_W-1:0]  s_axil_bresp,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    input  logic [G_ADDR_W-1:0]     s_axil_araddr,
    input  logic [AXIL_PROT_W-1:0]  s_axil_arprot,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic [G_DATA_W-1:0]     s_axil_rdata,
    output logic [AXIL_RESP_W-1:0]  s_axil_rresp,
    // downstream master port
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [G_ADDR_W-1:0]     m_axil_awaddr,
    output logic [AXIL_PROT_W-1:0]  m_axil_awprot,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    output logic [G_DATA_W-1:0]     m_axil_wdata,
    output logic [G_DATA_W/8-1:0]   m_axil_wstrb,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    input  logic [AXIL_RESP_W-1:0]  m_axil_bresp,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    output logic [G_ADDR_W-1:0]     m_axil_araddr,
    output logic [AXIL_PROT_W-1:0]  m_axil_arprot,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,
    input  logic [G_DATA_W-1:0]     m_axil_rdata,
    input  logic [AXIL_RESP_W-1:0]  m_axil_rresp
);

    localparam int AW_W = G_ADDR_W + AXIL_PROT_W;
    localparam int W_W  = G_DATA_W + G_DATA_W / 8;
    localparam int R_W  = G_DATA_W + AXIL_RESP_W;

    // Write address: {prot, addr}
    axil_skid_buf #(.G_W(AW_W)) u_aw (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .s_valid (s_axil_awvalid),
        .s_ready (s_axil_awready),
        .s_data  ({s_axil_awprot, s_axil_awaddr}),
        .m_valid (m_axil_awvalid),
        .m_ready (m_axil_awready),
        .m_data  ({m_axil_awprot, m_axil_awaddr})
    );

    // Write data: {strb, data}
    axil_skid_buf #(.G_W(W_W)) u_w (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .s_valid (s_axil_wvalid),
        .s_ready (s_axil_wready),
        .s_data  ({s_axil_wstrb, s_axil_wdata}),
        .m_valid (m_axil_wvalid),
        .m_ready (m_axil_wready),
        .m_data  ({m_axil_wstrb, m_axil_wdata})
    );

    // Read address: {prot, addr}
    axil_skid_buf #(.G_W(AW_W)) u_ar (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .s_valid (s_axil_arvalid),
        .s_ready (s_axil_arready),
        .s_data  ({s_axil_arprot, s_axil_araddr}),
        .m_valid (m_axil_arvalid),
        .m_ready (m_axil_arready),
        .m_data  ({m_axil_arprot, m_axil_araddr})
    );

`ifdef AXIL_REG_SLICE_RESP_EN
    // Write response, flowing from the master port back to the slave port.
    axil_skid_buf #(.G_W(AXIL_RESP_W)) u_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .s_valid (m_axil_bvalid),
        .s_ready (m_axil_bready),
        .s_data  (m_axil_bresp),
        .m_valid (s_axil_bvalid),
        .m_ready (s_axil_bready),
        .m_data  (s_axil_bresp)
    );

    // Read data: {resp, data}, flowing from the master port back to the slave port.
    axil_skid_buf #(.G_W(R_W)) u_r (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .s_valid (m_axil_rvalid),
        .s_ready (m_axil_rready),
        .s_data  ({m_axil_rresp, m_axil_rdata}),
        .m_valid (s_axil_rvalid),
        .m_ready (s_axil_rready),
        .m_data  ({s_axil_rresp, s_axil_rdata})
    );
`else
    logic [R_W-1:0] r_pass;

    // Zero-latency response path; forced quiet while reset is held.
    assign s_axil_bvalid = m_axil_bvalid & ~i_rst;
    assign s_axil_bresp  = i_rst ? '0 : m_axil_bresp;
    assign m_axil_bready = s_axil_bready & ~i_rst;

    assign r_pass        = i_rst ? '0 : {m_axil_rresp, m_axil_rdata};
    assign s_axil_rvalid = m_axil_rvalid & ~i_rst;
    assign s_axil_rresp  = r_pass[R_W-1:G_DATA_W];
    assign s_axil_rdata  = r_pass[G_DATA_W-1:0];
    assign m_axil_rready = s_axil_rready & ~i_rst;
`endif

endmodule

// File: tb/tb_axil_reg_slice.sv
// Directed bench for axil_reg_slice: reset values, forward latency, back-to-back
// streaming, skid fill/drain, reset while full, a short randomised W-channel run
// against a reference queue, and the response path in either build.
module tb_axil_reg_slice;
    import axil_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            s_axil_awvalid, s_axil_awready;
    logic [AW-1:0]   s_axil_awaddr;
    logic [2:0]      s_axil_awprot;
    logic            s_axil_wvalid, s_axil_wready;
    logic [DW-1:0]   s_axil_wdata;
    logic [DW/8-1:0] s_axil_wstrb;
    logic            s_axil_bvalid, s_axil_bready;
    logic [1:0]      s_axil_bresp;
    logic            s_axil_arvalid, s_axil_arready;
    logic [AW-1:0]   s_axil_araddr;
    logic [2:0]      s_axil_arprot;
    logic            s_axil_rvalid, s_axil_rready;
    logic [DW-1:0]   s_axil_rdata;
    logic [1:0]      s_axil_rresp;
    logic            m_axil_awvalid, m_axil_awready;
    logic [AW-1:0]   m_axil_awaddr;
    logic [2:0]      m_axil_awprot;
    logic            m_axil_wvalid, m_axil_wready;
    logic [DW-1:0]   m_axil_wdata;
    logic [DW/8-1:0] m_axil_wstrb;
    logic            m_axil_bvalid, m_axil_bready;
    logic [1:0]      m_axil_bresp;
    logic            m_axil_arvalid, m_axil_arready;
    logic [AW-1:0]   m_axil_araddr;
    logic [2:0]      m_axil_arprot;
    logic            m_axil_rvalid, m_axil_rready;
    logic [DW-1:0]   m_axil_rdata;
    logic [1:0]      m_axil_rresp;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    axil_reg_slice #(.G_ADDR_W(AW), .G_DATA_W(DW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic [35:0] ref_q[$];
    logic [35:0] exp_w;
    logic [35:0] held_w;
    logic        stalled;
    logic        pending;
    logic        in_hs;
    logic        out_hs;

    initial begin
        i_rst = 1'b1;
        s_axil_awvalid = 0; s_axil_awaddr = '0; s_axil_awprot = '0;
        s_axil_wvalid  = 0; s_axil_wdata  = '0; s_axil_wstrb  = '0;
        s_axil_arvalid = 0; s_axil_araddr = '0; s_axil_arprot = '0;
        s_axil_bready  = 1; s_axil_rready = 1;
        m_axil_awready = 1; m_axil_wready = 1; m_axil_arready = 1;
        m_axil_bvalid  = 1; m_axil_bresp  = 2'b11;
        m_axil_rvalid  = 1; m_axil_rdata  = 32'h1234_5678; m_axil_rresp = 2'b01;

        // Reset: everything quiet and zero
        step(); step();
        check("rst_s_awready", s_axil_awready, 0);
        check("rst_s_wready",  s_axil_wready,  0);
        check("rst_s_arready", s_axil_arready, 0);
        check("rst_m_awvalid", m_axil_awvalid, 0);
        check("rst_m_awaddr",  m_axil_awaddr,  0);
        check("rst_m_wdata",   m_axil_wdata,   0);
        check("rst_s_bvalid",  s_axil_bvalid,  0);
        check("rst_s_bresp",   s_axil_bresp,   0);
        check("rst_m_bready",  m_axil_bready,  0);
        check("rst_s_rvalid",  s_axil_rvalid,  0);
        check("rst_s_rdata",   s_axil_rdata,   0);
        check("rst_m_rready",  m_axil_rready,  0);

        m_axil_bvalid = 0; m_axil_rvalid = 0;
        i_rst = 1'b0;
        step();
        check("post_rst_s_awready", s_axil_awready, 1);
        check("post_rst_s_wready",  s_axil_wready,  1);
        check("post_rst_s_arready", s_axil_arready, 1);

        // AW then W forwarded with exactly one cycle of latency
        s_axil_awvalid = 1; s_axil_awaddr = 20'h00010; s_axil_awprot = 3'b101;
        #1;
        check("aw_lat_before", m_axil_awvalid, 0);
        step();
        check("aw_lat_valid", m_axil_awvalid, 1);
        check("aw_lat_addr",  m_axil_awaddr,  20'h00010);
        check("aw_lat_prot",  m_axil_awprot,  3'b101);
        s_axil_awvalid = 0;
        s_axil_wvalid = 1; s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF;
        step();
        check("aw_consumed", m_axil_awvalid, 0);
        check("w_lat_valid", m_axil_wvalid,  1);
        check("w_lat_data",  m_axil_wdata,   32'hDEAD_BEEF);
        check("w_lat_strb",  m_axil_wstrb,   4'hF);
        s_axil_wvalid = 0;
        step();
        check("w_consumed", m_axil_wvalid, 0);

        // Back-to-back AR, no bubbles
        s_axil_arvalid = 1; s_axil_araddr = 20'h4;
        step();
        check("ar0_valid", m_axil_arvalid, 1);
        check("ar0_addr",  m_axil_araddr,  20'h4);
        s_axil_araddr = 20'h8;
        step();
        check("ar1_valid", m_axil_arvalid, 1);
        check("ar1_addr",  m_axil_araddr,  20'h8);
        check("ar1_ready", s_axil_arready, 1);
        s_axil_araddr = 20'hC;
        step();
        check("ar2_valid", m_axil_arvalid, 1);
        check("ar2_addr",  m_axil_araddr,  20'hC);
        s_axil_arvalid = 0;
        step();
        check("ar_drained", m_axil_arvalid, 0);

        // AW stalled downstream: main + skid fill, third offer held off
        m_axil_awready = 0;
        s_axil_awvalid = 1; s_axil_awaddr = 20'hA1; s_axil_awprot = 3'b000;
        step();
        check("stall_ready1", s_axil_awready, 1);
        check("stall_addr1",  m_axil_awaddr,  20'hA1);
        s_axil_awaddr = 20'hA2;
        step();
        check("stall_ready2", s_axil_awready, 0);
        check("stall_hold2",  m_axil_awaddr,  20'hA1);
        s_axil_awaddr = 20'hA3;
        step();
        check("stall_ready3", s_axil_awready, 0);
        check("stall_hold3v", m_axil_awvalid, 1);
        check("stall_hold3",  m_axil_awaddr,  20'hA1);
        m_axil_awready = 1;
        step();
        check("drain_a2",       m_axil_awaddr,  20'hA2);
        check("drain_a2_valid", m_axil_awvalid, 1);
        check("drain_ready_up", s_axil_awready, 1);
        step();
        check("drain_a3",       m_axil_awaddr,  20'hA3);
        check("drain_a3_valid", m_axil_awvalid, 1);
        s_axil_awvalid = 0;
        step();
        check("drain_empty", m_axil_awvalid, 0);

        // Reset while W is full: nothing stale survives
        m_axil_wready = 0;
        s_axil_wvalid = 1; s_axil_wdata = 32'h1111_1111; s_axil_wstrb = 4'h1;
        step();
        s_axil_wdata = 32'h2222_2222; s_axil_wstrb = 4'h2;
        step();
        check("wfull_ready", s_axil_wready, 0);
        s_axil_wvalid = 0;
        i_rst = 1;
        step();
        check("wrst_valid", m_axil_wvalid, 0);
        check("wrst_data",  m_axil_wdata,  0);
        check("wrst_ready", s_axil_wready, 0);
        i_rst = 0; m_axil_wready = 1;
        step();
        check("wrst_rel_ready", s_axil_wready, 1);
        check("wrst_rel_valid", m_axil_wvalid, 0);
        step();
        check("wrst_no_stale", m_axil_wvalid, 0);

        // Randomised W traffic against a reference queue
        stalled = 0; pending = 0; held_w = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                s_axil_wvalid = (i < 370) ? ($urandom_range(0, 1) == 1) : 1'b0;
                s_axil_wdata  = $urandom;
                s_axil_wstrb  = 4'($urandom_range(0, 15));
            end
            m_axil_wready = (i < 370) ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            in_hs  = s_axil_wvalid && s_axil_wready;
            out_hs = m_axil_wvalid && m_axil_wready;
            if (stalled) begin
                check("rnd_hold_valid", m_axil_wvalid, 1);
                check("rnd_hold_data",  {m_axil_wstrb, m_axil_wdata}, held_w);
            end
            if (out_hs) begin
                if (ref_q.size() == 0) begin
                    check("rnd_unexpected", {m_axil_wstrb, m_axil_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_w = ref_q.pop_front();
                    check("rnd_data", {m_axil_wstrb, m_axil_wdata}, exp_w);
                end
            end
            if (in_hs) ref_q.push_back({s_axil_wstrb, s_axil_wdata});
            pending = s_axil_wvalid && !in_hs;
            stalled = m_axil_wvalid && !m_axil_wready;
            held_w  = {m_axil_wstrb, m_axil_wdata};
            @(posedge i_clk);
            #1;
        end
        s_axil_wvalid = 0;
        check("rnd_queue_empty", ref_q.size(), 0);
        check("rnd_out_idle",    m_axil_wvalid, 0);

        // Response path: SLVERR on B, data on R
        s_axil_bready = 1; s_axil_rready = 1;
        m_axil_bvalid = 1; m_axil_bresp = SLVERR;
        m_axil_rvalid = 1; m_axil_rdata = 32'hCAFE_F00D; m_axil_rresp = OKAY;
        #1;
`ifdef AXIL_REG_SLICE_RESP_EN
        check("b_reg_before",  s_axil_bvalid, 0);
        check("b_reg_mready",  m_axil_bready, 1);
        step();
        m_axil_bvalid = 0; m_axil_rvalid = 0;
        check("b_reg_valid",   s_axil_bvalid, 1);
        check("b_reg_resp",    s_axil_bresp,  2'b10);
        check("r_reg_valid",   s_axil_rvalid, 1);
        check("r_reg_data",    s_axil_rdata,  32'hCAFE_F00D);
        check("r_reg_resp",    s_axil_rresp,  2'b00);
        step();
        check("b_reg_drained", s_axil_bvalid, 0);
`else
        check("b_pass_valid",  s_axil_bvalid, 1);
        check("b_pass_resp",   s_axil_bresp,  2'b10);
        check("b_pass_mready", m_axil_bready, 1);
        check("r_pass_valid",  s_axil_rvalid, 1);
        check("r_pass_data",   s_axil_rdata,  32'hCAFE_F00D);
        check("r_pass_resp",   s_axil_rresp,  2'b00);
        s_axil_bready = 0;
        #1;
        check("b_pass_mready_lo", m_axil_bready, 0);
        m_axil_bvalid = 0; m_axil_rvalid = 0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
